// File: rtl/hack_mmio_ctrl.sv
// hack_mmio_ctrl: memory-mapped I/O block for the Hack SoC.
// Provides GPIO_COUNT writable GPIO words, a keyboard FIFO with a status word
// and a combinational read path for the CPU inM mux. CPU writes commit only
// on the hack_clk rising-edge strobe.
// Optional macro HACK_MMIO_GPIO_IN_EN adds a synchronised gpio_in port whose
// words are returned on GPIO reads instead of the output registers.
module hack_mmio_ctrl #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 15,
    parameter int KBD_ADDRESS    = 24576,
    parameter int GPIO_BASE      = 24577,
    parameter int GPIO_COUNT     = 2,
    parameter int KBD_FIFO_DEPTH = 4,
    parameter int KEYCODE_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             hack_clk_rise,
    input  logic                             hack_reset,
    input  logic [ADDRESS_WIDTH-1:0]         addressM,
    input  logic                             writeM,
    input  logic [WORD_WIDTH-1:0]            outM,
    output logic [WORD_WIDTH-1:0]            io_rdata,
    output logic                             io_hit,
    input  logic [KEYCODE_WIDTH-1:0]         keycode,
    input  logic                             keycode_valid,
`ifdef HACK_MMIO_GPIO_IN_EN
    input  logic [GPIO_COUNT*WORD_WIDTH-1:0] gpio_in,
`endif
    output logic [GPIO_COUNT*WORD_WIDTH-1:0] gpio
);

    localparam int PW  = (KBD_FIFO_DEPTH > 1) ? $clog2(KBD_FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(KBD_FIFO_DEPTH + 1);
    localparam int GIW = (GPIO_COUNT > 1) ? $clog2(GPIO_COUNT) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] KBD_A  = ADDRESS_WIDTH'(KBD_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] GPIO_A = ADDRESS_WIDTH'(GPIO_BASE);
    localparam logic [ADDRESS_WIDTH-1:0] STAT_A = ADDRESS_WIDTH'(GPIO_BASE + GPIO_COUNT);
    localparam logic [CW-1:0]            DEPTH_C = CW'(KBD_FIFO_DEPTH);

    // Register state
    logic [WORD_WIDTH-1:0]    gpio_q   [GPIO_COUNT];
    logic [WORD_WIDTH-1:0]    gpio_d   [GPIO_COUNT];
    logic [KEYCODE_WIDTH-1:0] mem_q    [KBD_FIFO_DEPTH];
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     ovf_q, ovf_d;

    // Decode and control
    logic                     kbd_sel, gpio_sel, stat_sel;
    logic [GIW-1:0]           gidx;
    logic                     wr_commit, wr_kbd, wr_gpio, wr_stat;
    logic                     fifo_full, fifo_empty;
    logic                     push_req, push_ok, pop_ok;
    logic [WORD_WIDTH-1:0]    status_word;
    logic [WORD_WIDTH-1:0]    gpio_rd  [GPIO_COUNT];

`ifdef HACK_MMIO_GPIO_IN_EN
    logic [GPIO_COUNT*WORD_WIDTH-1:0] gpio_in_s1_q, gpio_in_s2_q;
`endif

    // Address decode, write qualification and FIFO push/pop arbitration
    always_comb begin
        kbd_sel    = (addressM == KBD_A);
        gpio_sel   = (addressM >= GPIO_A) && (addressM < STAT_A);
        stat_sel   = (addressM == STAT_A);
        gidx       = GIW'(addressM - GPIO_A);
        io_hit     = kbd_sel || gpio_sel || stat_sel;

        wr_commit  = hack_clk_rise && writeM && io_hit;
        wr_kbd     = wr_commit && kbd_sel;
        wr_gpio    = wr_commit && gpio_sel;
        wr_stat    = wr_commit && stat_sel;

        fifo_full  = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);

        // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
        pop_ok     = wr_kbd && !fifo_empty && !hack_reset;
        push_req   = keycode_valid && (keycode != '0) && !hack_reset;
        push_ok    = push_req && (!fifo_full || pop_ok);
    end

    // Status word assembly
    always_comb begin
        status_word                 = '0;
        status_word[WORD_WIDTH-1]   = ovf_q;
        status_word[WORD_WIDTH-2]   = fifo_full;
        status_word[WORD_WIDTH-3]   = fifo_empty;
        status_word[CW-1:0]         = count_q;
    end

    // GPIO readback source per word
    for (genvar i = 0; i < GPIO_COUNT; i++) begin : g_gpio
        assign gpio[i*WORD_WIDTH +: WORD_WIDTH] = gpio_q[i];
`ifdef HACK_MMIO_GPIO_IN_EN
        assign gpio_rd[i] = gpio_in_s2_q[i*WORD_WIDTH +: WORD_WIDTH];
`else
        assign gpio_rd[i] = gpio_q[i];
`endif
    end

    // Combinational read mux into the CPU inM path
    always_comb begin
        io_rdata = '0;
        if (kbd_sel) begin
            if (!fifo_empty) begin
                io_rdata = WORD_WIDTH'(mem_q[rd_ptr_q]);
            end
        end else if (gpio_sel) begin
            io_rdata = gpio_rd[gidx];
        end else if (stat_sel) begin
            io_rdata = status_word;
        end
    end

    // Next-state for GPIO words, FIFO pointers/count and sticky overflow
    always_comb begin
        gpio_d   = gpio_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (hack_reset) begin
            gpio_d   = '{default: '0};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_gpio) begin
                gpio_d[gidx] = outM;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
            if (wr_stat && outM[WORD_WIDTH-1]) begin
                ovf_d = 1'b0;
            end
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_q   <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; an entry is only visible once count covers it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= keycode;
        end
    end

`ifdef HACK_MMIO_GPIO_IN_EN
    // Two-flop synchroniser for the asynchronous GPIO inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_in_s1_q <= '0;
            gpio_in_s2_q <= '0;
        end else begin
            gpio_in_s1_q <= gpio_in;
            gpio_in_s2_q <= gpio_in_s1_q;
        end
    end
`endif

endmodule

// File: tb/tb_hack_mmio_ctrl.sv
// Self-checking bench for hack_mmio_ctrl: queue-based behavioural model,
// per-cycle comparison of all outputs, and directed literal checks.
module tb_hack_mmio_ctrl;

    localparam int WW    = 16;
    localparam int AW    = 15;
    localparam int KBD   = 24576;
    localparam int GB    = 24577;
    localparam int GC    = 2;
    localparam int DEPTH = 4;
    localparam int KW    = 8;
    localparam int STAT  = GB + GC;

    logic              clk;
    logic              reset_n;
    logic              hack_clk_rise;
    logic              hack_reset;
    logic [AW-1:0]     addressM;
    logic              writeM;
    logic [WW-1:0]     outM;
    logic [WW-1:0]     io_rdata;
    logic              io_hit;
    logic [KW-1:0]     keycode;
    logic              keycode_valid;
    logic [GC*WW-1:0]  gpio;
`ifdef HACK_MMIO_GPIO_IN_EN
    logic [GC*WW-1:0]  gpio_in;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 0;

    hack_mmio_ctrl #(
        .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .KBD_ADDRESS(KBD), .GPIO_BASE(GB),
        .GPIO_COUNT(GC), .KBD_FIFO_DEPTH(DEPTH), .KEYCODE_WIDTH(KW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hack_clk_rise(hack_clk_rise),
        .hack_reset(hack_reset), .addressM(addressM), .writeM(writeM),
        .outM(outM), .io_rdata(io_rdata), .io_hit(io_hit), .keycode(keycode),
        .keycode_valid(keycode_valid),
`ifdef HACK_MMIO_GPIO_IN_EN
        .gpio_in(gpio_in),
`endif
        .gpio(gpio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [WW-1:0] m_gpio [GC];
    logic [KW-1:0] m_q [$];
    bit            m_ovf;
    logic [GC*WW-1:0] m_s1, m_s2;
    int            m_a;
    bit            m_commit;

    initial begin
        m_gpio[0] = '0; m_gpio[1] = '0; m_ovf = 0; m_s1 = '0; m_s2 = '0;
    end

    function automatic bit exp_hit(input int a);
        return (a == KBD) || (a >= GB && a < GB + GC) || (a == STAT);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || hack_reset) begin
            m_gpio[0] = '0;
            m_gpio[1] = '0;
            m_q.delete();
            m_ovf = 0;
        end else begin
            m_a = int'(addressM);
            m_commit = hack_clk_rise && writeM && exp_hit(m_a);
            if (m_commit && m_a == KBD && m_q.size() > 0) void'(m_q.pop_front());
            if (m_commit && m_a >= GB && m_a < GB + GC) m_gpio[m_a - GB] = outM;
            if (m_commit && m_a == STAT && outM[15]) m_ovf = 0;
            if (keycode_valid && keycode != 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(keycode);
                else m_ovf = 1;
            end
        end
    end

`ifdef HACK_MMIO_GPIO_IN_EN
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0;
        end else begin
            m_s2 = m_s1; m_s1 = gpio_in;
        end
    end
`endif

    function automatic logic [WW-1:0] exp_rd(input int a);
        logic [WW-1:0] r;
        r = '0;
        if (a == KBD) begin
            if (m_q.size() > 0) r = WW'(m_q[0]);
        end else if (a >= GB && a < GB + GC) begin
`ifdef HACK_MMIO_GPIO_IN_EN
            r = m_s2[(a - GB)*WW +: WW];
`else
            r = m_gpio[a - GB];
`endif
        end else if (a == STAT) begin
            r[15]  = m_ovf;
            r[14]  = (m_q.size() == DEPTH);
            r[13]  = (m_q.size() == 0);
            r[2:0] = 3'(m_q.size());
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdata", 32'(io_rdata), 32'(exp_rd(int'(addressM))));
            check("model_hit", 32'(io_hit), 32'(exp_hit(int'(addressM))));
            check("model_gpio", gpio, {m_gpio[1], m_gpio[0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rise, input logic wr, input int addr,
                         input logic [WW-1:0] data, input logic kv,
                         input logic [KW-1:0] kc, input logic hr);
        hack_clk_rise = rise;
        writeM        = wr;
        addressM      = AW'(addr);
        outM          = data;
        keycode_valid = kv;
        keycode       = kc;
        hack_reset    = hr;
        @(posedge clk);
        #1;
        hack_clk_rise = 1'b0;
        writeM        = 1'b0;
        keycode_valid = 1'b0;
        hack_reset    = 1'b0;
    endtask

    task automatic push(input logic [KW-1:0] kc);
        drive(1'b0, 1'b0, KBD, '0, 1'b1, kc, 1'b0);
    endtask

    task automatic pop();
        drive(1'b1, 1'b1, KBD, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input int addr, input logic [WW-1:0] data);
        drive(1'b1, 1'b1, addr, data, 1'b0, '0, 1'b0);
    endtask

    task automatic peek(input int addr, input logic [WW-1:0] exp, input string name);
        addressM = AW'(addr);
        @(negedge clk);
        check(name, 32'(io_rdata), 32'(exp));
    endtask

    int          hit_addr [6] = '{24575, 24576, 24577, 24578, 24579, 24580};
    logic        hit_exp  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset_n = 1'b0; hack_clk_rise = 1'b0; hack_reset = 1'b0; addressM = '0;
        writeM = 1'b0; outM = '0; keycode = '0; keycode_valid = 1'b0;
`ifdef HACK_MMIO_GPIO_IN_EN
        gpio_in = '0;
`endif
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1;

        // Reset state and decode map
        peek(KBD, 16'h0000, "rst_kbd");
        peek(STAT, 16'h2000, "rst_stat");
        check("rst_gpio", gpio, 32'h0);
        for (int i = 0; i < 6; i++) begin
            addressM = AW'(hit_addr[i]);
            @(negedge clk);
            check("hit_map", 32'(io_hit), 32'(hit_exp[i]));
        end

        // GPIO writes, ungated writes and unmapped writes
        wr(24578, 16'hBEEF);
        @(negedge clk);
        check("gpio_beef", gpio, 32'hBEEF_0000);
        drive(1'b0, 1'b1, 24577, 16'h1111, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 24578, 16'h5555, 1'b0, '0, 1'b0);
        wr(24580, 16'h7777);
        @(negedge clk);
        check("gpio_norise", gpio, 32'hBEEF_0000);
`ifndef HACK_MMIO_GPIO_IN_EN
        peek(24578, 16'hBEEF, "gpio_read");
`endif

        // FIFO ordering
        push(8'h41); push(8'h42); push(8'h43);
        peek(KBD, 16'h0041, "fifo_head");
        peek(STAT, 16'h0003, "fifo_cnt3");
        pop(); pop();
        peek(KBD, 16'h0043, "fifo_after2");
        pop();
        peek(KBD, 16'h0000, "fifo_drained");
        peek(STAT, 16'h2000, "fifo_empty");
        push(8'h00);
        pop();
        peek(STAT, 16'h2000, "zero_and_emptypop");

        // Overflow and clear
        for (int k = 1; k <= 5; k++) push(KW'(k));
        peek(STAT, 16'hC004, "ovf_stat");
        peek(KBD, 16'h0001, "ovf_head");
        wr(STAT, 16'h8000);
        peek(STAT, 16'h4004, "ovf_clear");

        // Simultaneous push+pop when full
        drive(1'b1, 1'b1, KBD, '0, 1'b1, 8'h66, 1'b0);
        peek(STAT, 16'h4004, "full_pushpop_stat");
        peek(KBD, 16'h0002, "full_pushpop_head");
        pop(); pop(); pop();
        peek(KBD, 16'h0066, "wrap_tail");
        pop();
        peek(STAT, 16'h2000, "drain_full");

        // Simultaneous push+pop when empty
        drive(1'b1, 1'b1, KBD, '0, 1'b1, 8'h77, 1'b0);
        peek(STAT, 16'h0001, "empty_pushpop_stat");
        peek(KBD, 16'h0077, "empty_pushpop_head");

        // hack_reset discards same-cycle push and write
        wr(24577, 16'h1234);
        push(8'h55);
        peek(STAT, 16'h0002, "pre_hreset");
        drive(1'b1, 1'b1, 24578, 16'hAAAA, 1'b1, 8'h99, 1'b1);
        @(negedge clk);
        check("hreset_gpio", gpio, 32'h0);
        peek(STAT, 16'h2000, "hreset_stat");
        peek(KBD, 16'h0000, "hreset_kbd");

        // Asynchronous reset during a push
        push(8'h10);
        wr(24577, 16'h00AB);
        keycode = 8'h20;
        keycode_valid = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 keycode_valid = 1'b0;
        #2 reset_n = 1'b1;
        peek(STAT, 16'h2000, "areset_stat");
        check("areset_gpio", gpio, 32'h0);

`ifdef HACK_MMIO_GPIO_IN_EN
        gpio_in = 32'h0000_00FF;
        @(posedge clk); @(posedge clk); #1;
        peek(GB, 16'h00FF, "gpio_in_sync");
`endif

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hack_mmio_ctrl.md
Name: hack_mmio_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the Hack SoC; replaces the fixed single GPIO word and the raw keyboard mux in the top level.
- Provides GPIO_COUNT writable GPIO words, a keyboard FIFO of KBD_FIFO_DEPTH entries with a status word, and a combinational read path into the CPU's inM mux.
- Runs on the system clk and commits CPU writes only on the hack_clk rising-edge strobe.

Parameters:
- WORD_WIDTH, 16, CPU data word width.
- ADDRESS_WIDTH, 15, width of addressM.
- KBD_ADDRESS, 24576, keyboard FIFO head address.
- GPIO_BASE, 24577, address of GPIO word 0; words are contiguous.
- GPIO_COUNT, 2, number of GPIO words (1..8).
- KBD_FIFO_DEPTH, 4, number of FIFO entries (power of two, 2..16).
- KEYCODE_WIDTH, 8, keycode width; zero-extended to WORD_WIDTH on read.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hack_clk_rise  in  1  one-clk pulse marking the hack_clk rising edge; qualifies all CPU writes.
- hack_reset  in  1  synchronous active-high CPU reset; clears state as described under Behaviour.
- addressM  in  ADDRESS_WIDTH  CPU data address.
- writeM  in  1  CPU write request.
- outM  in  WORD_WIDTH  CPU write data.
- io_rdata  out  WORD_WIDTH  read data for the inM mux; combinational from addressM.
- io_hit  out  1  high when addressM decodes to any register in this block.
- keycode  in  KEYCODE_WIDTH  key code from the keyboard front end.
- keycode_valid  in  1  one-clk push strobe.
- gpio  out  GPIO_COUNT*WORD_WIDTH  GPIO registers; word i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].

Behaviour:
- Address map:
  - KBD_ADDRESS: FIFO head.
  - GPIO_BASE .. GPIO_BASE+GPIO_COUNT-1: GPIO words.
  - STATUS = GPIO_BASE+GPIO_COUNT.
  - io_hit=0 and io_rdata=0 for every other address.
- Write commit:
  - A write takes effect on the clk edge where hack_clk_rise && writeM && the address decodes to this block.
  - Writes with hack_clk_rise=0 are ignored.
  - Written registers are visible on io_rdata the following clk cycle.
- GPIO: a write loads word i with outM.
- FIFO pop: a committed write to KBD_ADDRESS pops the head; the data value is ignored.
- FIFO push: keycode_valid=1 with keycode!=0 pushes keycode. keycode_valid=1 with keycode==0 is ignored.
- KBD read: returns the zero-extended head; returns 0 when the FIFO is empty, which preserves the Hack "no key" semantic.
- STATUS read:
  - bit 15 = overflow (sticky).
  - bit 14 = full.
  - bit 13 = empty.
  - bits [CW-1:0] = occupancy count, where CW = clog2(KBD_FIFO_DEPTH+1).
  - All other bits read 0.
- STATUS write: a write with outM[15]=1 clears overflow; all other bits are read-only.
- Boundary cases:
  - Push when full: keycode dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle, not empty: both happen, count unchanged.
  - Push and pop in the same cycle, full: pop and push both accepted, overflow not set.
  - Push and pop in the same cycle, empty: pop ignored, push accepted, count becomes 1.
  - Pop when empty: no effect, no error flag.
  - Pointers wrap modulo KBD_FIFO_DEPTH.
- Reset values, reset_n=0 (asynchronous): gpio=0, FIFO empty (count=0, pointers=0), overflow=0. io_rdata is therefore 0 for KBD and 0x2000 for STATUS.
- hack_reset=1 (synchronous, on any clk edge): gpio=0, FIFO flushed, overflow cleared; pushes and writes in that cycle are discarded.
- Reset mid-operation: reset_n asserted during a push or pop aborts it; no partial entry survives.
- No wait states: the block is never busy; read latency is 0 cycles (combinational).

Optional Feature:
- Macro HACK_MMIO_GPIO_IN_EN.
- When defined:
  - Adds input port gpio_in [GPIO_COUNT*WORD_WIDTH].
  - gpio_in passes through a 2-flop synchroniser, reset to 0.
  - Reads of GPIO word i return synchronised gpio_in word i; writes still update the gpio output.
  - Input-to-readback latency is 2 clk.
- When undefined: no gpio_in port; GPIO reads return the gpio output register.

Test Plan:
- Reset: reset_n low, then high -> gpio=0; io_rdata at KBD = 0x0000; io_rdata at STATUS = 0x2000; io_hit=1 at 24576..24579 and 0 at 24580.
- GPIO write: at 24578 write 0xBEEF with hack_clk_rise=1 -> gpio[31:16]=0xBEEF, gpio[15:0] unchanged. Same write with hack_clk_rise=0 -> no change.
- FIFO order: push 0x41, 0x42, 0x43 -> KBD reads 0x0041, STATUS count=3. Pop twice -> KBD reads 0x0043. Pop once more -> KBD reads 0x0000 and empty=1.
- Overflow: push 5 keys into depth 4 -> STATUS=0xC004, 5th key lost. Write 0x8000 to STATUS -> STATUS=0x4004.
- Simultaneous: with FIFO full, push and pop in the same cycle -> count stays 4, overflow stays 0, head advances. With FIFO empty, push and pop in the same cycle -> count=1.
- hack_reset: with gpio=0x1234 and 2 keys queued, pulse hack_reset for 1 clk -> gpio=0, STATUS=0x2000. With HACK_MMIO_GPIO_IN_EN, set gpio_in word 0 = 0x00FF -> GPIO_BASE reads 0x00FF after 2 clk.
